// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches a missing cache line word-by-word and returns it whole.
// Define CACHE_WRITEBACK_EN to write back a dirty victim line before the refill.
module cache_refill_ctrl #(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = 16,
  localparam int WORDS     = BLOCK_SIZE * 8 / DATA_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [ADDR_SIZE-1:0]       miss_addr,
  input  logic                       victim_dirty,
  input  logic [ADDR_SIZE-1:0]       victim_addr,
  input  logic [WORDS*DATA_SIZE-1:0] victim_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_SIZE-1:0]       mem_addr,
  output logic [DATA_SIZE-1:0]       mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_SIZE-1:0]       mem_rdata,
  output logic                       fill_valid,
  input  logic                       fill_ready,
  output logic [ADDR_SIZE-1:0]       fill_addr,
  output logic [WORDS*DATA_SIZE-1:0] fill_data,
  output logic                       busy
);
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WSH = $clog2(DATA_SIZE / 8);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  localparam logic [1:0] IDLE = 2'd0, WB = 2'd1, FETCH = 2'd2, RESP = 2'd3;

  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] line_q, line_d;
  logic [WORDS*DATA_SIZE-1:0] line_data_q, line_data_d;
  logic [ADDR_SIZE-1:0] base;
  logic last;
  logic wb_go;
  logic unused_lo;

  assign unused_lo = ^{miss_addr[OFFSET_BITS-1:0], victim_addr[OFFSET_BITS-1:0]};
  assign last = cnt_q == LAST;
  assign miss_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign mem_req = state_q == WB || state_q == FETCH;
  assign fill_valid = state_q == RESP;
  assign fill_addr = line_q;
  assign fill_data = line_data_q;
  assign mem_addr = base + (ADDR_SIZE'(cnt_q) << WSH);

`ifdef CACHE_WRITEBACK_EN
  logic [ADDR_SIZE-1:0] vaddr_q, vaddr_d;
  logic [WORDS*DATA_SIZE-1:0] vdata_q, vdata_d;
  assign wb_go = victim_dirty;
  assign base = state_q == WB ? vaddr_q : line_q;
  assign mem_we = state_q == WB;
  assign mem_wdata = mem_we ? vdata_q[int'(cnt_q)*DATA_SIZE +: DATA_SIZE] : '0;
  always_comb begin
    vaddr_d = miss_valid && miss_ready && victim_dirty ?
              {victim_addr[ADDR_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : vaddr_q;
    vdata_d = miss_valid && miss_ready && victim_dirty ? victim_data : vdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vaddr_q <= '0;
      vdata_q <= '0;
    end else begin
      vaddr_q <= vaddr_d;
      vdata_q <= vdata_d;
    end
  end
`else
  logic unused_victim;
  assign unused_victim = ^{victim_dirty, victim_addr, victim_data};
  assign wb_go = 1'b0;
  assign base = line_q;
  assign mem_we = 1'b0;
  assign mem_wdata = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    line_d = line_q;
    line_data_d = line_data_q;
    case (state_q)
      IDLE: if (miss_valid) begin
        state_d = wb_go ? WB : FETCH;
        cnt_d = '0;
        line_d = {miss_addr[ADDR_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
      WB: if (mem_ack) begin
        state_d = last ? FETCH : WB;
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      FETCH: if (mem_ack) begin
        line_data_d[int'(cnt_q)*DATA_SIZE +: DATA_SIZE] = mem_rdata;
        state_d = last ? RESP : FETCH;
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      default: state_d = fill_ready ? IDLE : RESP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      line_q <= '0;
      line_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      line_q <= line_d;
      line_data_q <= line_data_d;
    end
  end
endmodule
